// File: rtl/flit_compressor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : flit_compressor                                                 |
// | Purpose  : Base-delta flit compressor with a 2-stage valid/ready pipeline. |
// | Option   : FLITZIP_STATS_EN adds raw_cnt/comp_cnt handshake counters.      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module flit_compressor #(
  parameter int INPUT_WIDTH = 128,
  parameter int CHUNK_SIZE  = 8,
  parameter int EN_BITS     = 3,
  parameter int NUM_CHUNKS  = INPUT_WIDTH / CHUNK_SIZE
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   is_head,
  input  logic [INPUT_WIDTH-1:0] data_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INPUT_WIDTH-1:0] data_out,
  output logic [EN_BITS-1:0]     en_bits,
  output logic [CHUNK_SIZE-1:0]  base,
  output logic                   head_out,
  output logic [1:0]             flit_idx
`ifdef FLITZIP_STATS_EN
  ,
  output logic [15:0]            raw_cnt,
  output logic [15:0]            comp_cnt
`endif
);

  localparam int MAX_W = CHUNK_SIZE - 1;

  // Handshake / flow control
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic s1_en_w, s2_en_w, acc_w;

  assign s2_en_w  = !s2_valid_q || out_ready;
  assign s1_en_w  = !s1_valid_q || s2_en_w;
  assign in_ready = !rst_in && s1_en_w;
  assign acc_w    = in_valid && in_ready;

  // Stage-0 combinational: deltas against chunk 0 and minimal width
  logic [CHUNK_SIZE-1:0]  base_w;
  logic [INPUT_WIDTH-1:0] enc_w;
  logic [MAX_W:1]         fit_w;
  logic [EN_BITS-1:0]     width_w;

  assign base_w = CHUNK_SIZE'(0) - data_in[CHUNK_SIZE-1:0];

  for (genvar gi = 0; gi < NUM_CHUNKS; gi++) begin : g_enc
    assign enc_w[gi*CHUNK_SIZE +: CHUNK_SIZE] = data_in[gi*CHUNK_SIZE +: CHUNK_SIZE] + base_w;
  end

  // A delta fits in w signed bits when everything from bit w-1 upward is sign copies.
  always_comb begin
    fit_w = '1;
    for (int w = 1; w <= MAX_W; w++) begin
      for (int i = 0; i < NUM_CHUNKS; i++) begin
        logic signed [CHUNK_SIZE-1:0] ce;
        logic signed [CHUNK_SIZE-1:0] sh;
        ce = $signed(enc_w[i*CHUNK_SIZE +: CHUNK_SIZE]);
        sh = ce >>> (w - 1);
        if (sh != '0 && sh != '1) begin
          fit_w[w] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    width_w = '0;
    for (int w = MAX_W; w >= 1; w--) begin
      if (fit_w[w]) begin
        width_w = EN_BITS'(w);
      end
    end
  end

  // Flit position counter; 3 doubles as the "no head seen" state.
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] idx_w;

  assign idx_w = is_head ? 2'd0 : ((cnt_q == 2'd3) ? 2'd3 : cnt_q + 2'd1);

  // Stage 1 registers
  logic [INPUT_WIDTH-1:0] s1_enc_q;
  logic [EN_BITS-1:0]     s1_w_q;
  logic [CHUNK_SIZE-1:0]  s1_base_q;
  logic                   s1_head_q;
  logic [1:0]             s1_idx_q;

  // Stage-1 combinational: pack for every candidate width, rebuild raw data
  logic [MAX_W:1][INPUT_WIDTH-1:0] pack_all;
  logic [INPUT_WIDTH-1:0]          raw_w;

  for (genvar gw = 1; gw <= MAX_W; gw++) begin : g_pack
    for (genvar gc = 0; gc < NUM_CHUNKS; gc++) begin : g_field
      assign pack_all[gw][gc*gw +: gw] = s1_enc_q[gc*CHUNK_SIZE +: gw];
    end
    assign pack_all[gw][INPUT_WIDTH-1:NUM_CHUNKS*gw] = '0;
  end

  for (genvar gr = 0; gr < NUM_CHUNKS; gr++) begin : g_raw
    assign raw_w[gr*CHUNK_SIZE +: CHUNK_SIZE] = s1_enc_q[gr*CHUNK_SIZE +: CHUNK_SIZE] - s1_base_q;
  end

  logic [INPUT_WIDTH-1:0] s2_data_d;
  logic [CHUNK_SIZE-1:0]  s2_base_d;

  always_comb begin
    s2_data_d = raw_w;
    s2_base_d = '0;
    if (s1_w_q != '0) begin
      s2_base_d = s1_base_q;
      for (int w = 1; w <= MAX_W; w++) begin
        if (s1_w_q == EN_BITS'(w)) begin
          s2_data_d = pack_all[w];
        end
      end
    end
  end

  // Stage 2 registers (drive the outputs directly)
  logic [INPUT_WIDTH-1:0] s2_data_q;
  logic [EN_BITS-1:0]     s2_w_q;
  logic [CHUNK_SIZE-1:0]  s2_base_q;
  logic                   s2_head_q;
  logic [1:0]             s2_idx_q;

  always_comb begin
    s1_valid_d = s1_en_w ? acc_w : s1_valid_q;
    s2_valid_d = s2_en_w ? s1_valid_q : s2_valid_q;
    cnt_d      = acc_w ? idx_w : cnt_q;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      cnt_q      <= 2'd3;
      s1_enc_q   <= '0;
      s1_w_q     <= '0;
      s1_base_q  <= '0;
      s1_head_q  <= 1'b0;
      s1_idx_q   <= 2'd0;
      s2_data_q  <= '0;
      s2_w_q     <= '0;
      s2_base_q  <= '0;
      s2_head_q  <= 1'b0;
      s2_idx_q   <= 2'd0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      cnt_q      <= cnt_d;
      if (acc_w) begin
        s1_enc_q  <= enc_w;
        s1_w_q    <= width_w;
        s1_base_q <= base_w;
        s1_head_q <= is_head;
        s1_idx_q  <= idx_w;
      end
      if (s2_en_w && s1_valid_q) begin
        s2_data_q <= s2_data_d;
        s2_w_q    <= s1_w_q;
        s2_base_q <= s2_base_d;
        s2_head_q <= s1_head_q;
        s2_idx_q  <= s1_idx_q;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign data_out  = s2_data_q;
  assign en_bits   = s2_w_q;
  assign base      = s2_base_q;
  assign head_out  = s2_head_q;
  assign flit_idx  = s2_idx_q;

`ifdef FLITZIP_STATS_EN
  logic [15:0] raw_cnt_q, comp_cnt_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      raw_cnt_q  <= 16'd0;
      comp_cnt_q <= 16'd0;
    end else if (s2_valid_q && out_ready) begin
      if (s2_w_q == '0) begin
        raw_cnt_q <= raw_cnt_q + 16'd1;
      end else begin
        comp_cnt_q <= comp_cnt_q + 16'd1;
      end
    end
  end

  assign raw_cnt  = raw_cnt_q;
  assign comp_cnt = comp_cnt_q;
`endif

endmodule
`default_nettype wire
